// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result, commits it into a 64-entry register file with
// combinational read ports and same-cycle bypass, and publishes the last commit for forwarding.
module writeback_regfile #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              RegWriteDIN,
    input  logic              MemtoRegDIN,
    input  logic [DATA_W-1:0] ALUIN,
    input  logic [DATA_W-1:0] ReadDataWIN,
    input  logic [ADDR_W-1:0] WriteRegEIN,
    output logic [DATA_W-1:0] ResultWOUT,
    input  logic [ADDR_W-1:0] RA1IN,
    input  logic [ADDR_W-1:0] RA2IN,
    output logic [DATA_W-1:0] RD1OUT,
    output logic [DATA_W-1:0] RD2OUT,
    output logic              FwdValidOUT,
    output logic [ADDR_W-1:0] FwdRegOUT,
    output logic [DATA_W-1:0] FwdDataOUT,
    output logic [CNT_W-1:0]  CommitCntOUT
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              commit;
    logic [DATA_W-1:0] regs_view [DEPTH];
    logic              fwd_valid_reg;
    logic [ADDR_W-1:0] fwd_reg_reg;
    logic [DATA_W-1:0] fwd_data_reg;
    logic [CNT_W-1:0]  cnt_reg;

    assign ResultWOUT = MemtoRegDIN ? ReadDataWIN : ALUIN;
    assign commit     = enable & RegWriteDIN & (WriteRegEIN != '0);

    // Storage is flop-based: reads are combinational and reset clears every entry,
    // which a block RAM cannot provide. Entry 0 is a constant, not a register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_view[gi] = '0;
            end else begin : g_entry
                logic [DATA_W-1:0] q_reg;
                logic              wr_en;

                assign wr_en = commit & (WriteRegEIN == ADDR_W'(gi));

                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (wr_en) begin
                        q_reg <= ResultWOUT;
                    end
                end

                assign regs_view[gi] = q_reg;
            end
        end
    endgenerate

    // Bypass only when a commit is actually happening, so stalls read plain storage.
    always_comb begin
        RD1OUT = '0;
        if (RA1IN != '0) begin
            if (commit && (RA1IN == WriteRegEIN)) begin
                RD1OUT = ResultWOUT;
            end else begin
                RD1OUT = regs_view[RA1IN];
            end
        end
    end

    always_comb begin
        RD2OUT = '0;
        if (RA2IN != '0) begin
            if (commit && (RA2IN == WriteRegEIN)) begin
                RD2OUT = ResultWOUT;
            end else begin
                RD2OUT = regs_view[RA2IN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_reg <= 1'b0;
            fwd_reg_reg   <= '0;
            fwd_data_reg  <= '0;
            cnt_reg       <= '0;
        end else if (enable) begin
            fwd_valid_reg <= commit;
            fwd_reg_reg   <= WriteRegEIN;
            fwd_data_reg  <= ResultWOUT;
            if (commit && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign FwdValidOUT  = fwd_valid_reg;
    assign FwdRegOUT    = fwd_reg_reg;
    assign FwdDataOUT   = fwd_data_reg;
    assign CommitCntOUT = cnt_reg;

endmodule
